// File: rtl/uart_tx_engine_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_engine_pkg
// Shared SCI transmit definitions:
//   - tx_state_e        : FSM state encodings (IDLE, START, DATA, PARITY, STOP)
//   - PARITY_EVEN/ODD   : parity-mode constants for the parity-select input
//   - DIV_W_DEF         : default width of the baud divisor
//   - calc_parity()     : parity bit for a byte under the selected mode
// -----------------------------------------------------------------------------
package uart_tx_engine_pkg;

   localparam int DIV_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic calc_parity(input logic [7:0] i_data, input logic i_odd);
      return (^i_data) ^ (i_odd == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_engine_if
// Byte request handshake, per-frame configuration and status of the transmit
// engine.
//   iTX_VALID/iTX_DATA  : byte request from the TX FIFO / register logic
//   iBAUD_DIV           : clocks per bit minus 1
//   iPARITY_EN/ODD      : parity enable / odd-parity select
//   iSTOP2              : two stop bits
//   oTX_READY/oTX_DONE  : engine idle / one-cycle frame completion pulse
//   dbg_state           : current FSM state, for observation only
// Handshake: a byte is transferred on a rising clock edge where iTX_VALID and
// oTX_READY are both high; iTX_DATA and the configuration inputs are captured
// on that edge. iTX_VALID is ignored whenever oTX_READY is low.
// modports: master = requester side, slave = engine side.
// -----------------------------------------------------------------------------
interface uart_tx_engine_if #(parameter int DIV_W = 16) ();
   import uart_tx_engine_pkg::*;

   logic             iTX_VALID;
   logic [7:0]       iTX_DATA;
   logic [DIV_W-1:0] iBAUD_DIV;
   logic             iPARITY_EN;
   logic             iPARITY_ODD;
   logic             iSTOP2;
   logic             oTX_READY;
   logic             oTX_DONE;
   tx_state_e        dbg_state;

   modport master (
      output iTX_VALID, iTX_DATA, iBAUD_DIV, iPARITY_EN, iPARITY_ODD, iSTOP2,
      input  oTX_READY, oTX_DONE, dbg_state
   );

   modport slave (
      input  iTX_VALID, iTX_DATA, iBAUD_DIV, iPARITY_EN, iPARITY_ODD, iSTOP2,
      output oTX_READY, oTX_DONE, dbg_state
   );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_timer
// Per-bit up-counter. Counts clocks from 0 and raises o_bit_end in the cycle
// where the count equals i_div, so one bit lasts i_div+1 clocks.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_sync_rst     : synchronous clear (soft reset/abort)
//   i_clear        : reload to 0 (held in idle and on every bit boundary)
//   i_div          : latched divisor
//   o_bit_end      : one-cycle strobe in the last clock of a bit
// -----------------------------------------------------------------------------
module uart_tx_bit_timer
   import uart_tx_engine_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sync_rst,
   input  logic             i_clear,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_bit_end
);

   localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_sync_rst || i_clear) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + ONE;
      end
   end

   assign o_bit_end = (r_cnt == i_div);

endmodule

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// SCI transmit serialiser: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. One byte per valid/ready handshake, one-cycle done pulse.
//   iCLOCK      : bus clock
//   inRESET     : asynchronous active-low reset
//   iRESET_SYNC : synchronous soft reset / frame abort, active high
//   tx_if       : handshake, configuration and status (slave modport)
//   oUART_TXD   : serial line, idle high, registered
// -----------------------------------------------------------------------------
module uart_tx_engine
   import uart_tx_engine_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic           iCLOCK,
   input  logic           inRESET,
   input  logic           iRESET_SYNC,
   uart_tx_engine_if.slave tx_if,
   output logic           oUART_TXD
);

   tx_state_e        r_state;
   logic [7:0]       r_data;
   logic [2:0]       r_idx;
   logic [DIV_W-1:0] r_div;
   logic             r_par_en;
   logic             r_par_bit;
   logic             r_stop2;
   logic             r_stop_idx;
   logic             r_txd;
   logic             r_ready;
   logic             r_done;

   logic             w_bit_end;
   logic             w_timer_clr;
   logic [2:0]       w_next_idx;

   // Holding the timer cleared in idle makes the start bit begin at count 0.
   assign w_timer_clr = (r_state == ST_IDLE) || w_bit_end;
   assign w_next_idx  = r_idx + 3'd1;

   uart_tx_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
      .i_clk      (iCLOCK),
      .i_rst_n    (inRESET),
      .i_sync_rst (iRESET_SYNC),
      .i_clear    (w_timer_clr),
      .i_div      (r_div),
      .o_bit_end  (w_bit_end)
   );

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_state    <= ST_IDLE;
         r_data     <= '0;
         r_idx      <= '0;
         r_div      <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_stop2    <= 1'b0;
         r_stop_idx <= 1'b0;
         r_txd      <= 1'b1;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
      end else if (iRESET_SYNC) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_stop_idx <= 1'b0;
         r_txd      <= 1'b1;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_txd <= 1'b1;
               if (tx_if.iTX_VALID && r_ready) begin
                  r_data    <= tx_if.iTX_DATA;
                  r_div     <= tx_if.iBAUD_DIV;
                  r_par_en  <= tx_if.iPARITY_EN;
                  r_par_bit <= calc_parity(tx_if.iTX_DATA, tx_if.iPARITY_ODD);
                  r_stop2   <= tx_if.iSTOP2;
                  r_ready   <= 1'b0;
                  r_txd     <= 1'b0;
                  r_state   <= ST_START;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_idx   <= '0;
                  r_txd   <= r_data[0];
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  if (r_idx == 3'd7) begin
                     if (r_par_en) begin
                        r_txd   <= r_par_bit;
                        r_state <= ST_PARITY;
                     end else begin
                        r_txd      <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= ST_STOP;
                     end
                  end else begin
                     r_idx <= w_next_idx;
                     r_txd <= r_data[w_next_idx];
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_txd      <= 1'b1;
                  r_stop_idx <= 1'b0;
                  r_state    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  // Second stop bit reuses the state; the timer reload on
                  // w_bit_end starts a fresh bit period.
                  if (r_stop2 && !r_stop_idx) begin
                     r_stop_idx <= 1'b1;
                  end else begin
                     r_stop_idx <= 1'b0;
                     r_done     <= 1'b1;
                     r_ready    <= 1'b1;
                     r_state    <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign oUART_TXD       = r_txd;
   assign tx_if.oTX_READY = r_ready;
   assign tx_if.oTX_DONE  = r_done;
   assign tx_if.dbg_state = r_state;

endmodule
